// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, redirect input from
// the core, and the valid/ready instruction stream to decode.
interface inst_fetch_unit_if #(
  parameter int PC_WIDTH   = 5,
  parameter int INST_WIDTH = 32
) ();

  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic [INST_WIDTH-1:0] imem_data;
  logic                  redirect;
  logic [PC_WIDTH-1:0]   redirect_target;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [INST_WIDTH-1:0] inst;
  logic [PC_WIDTH-1:0]   inst_pc;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_data, redirect, redirect_target, inst_ready
  );

  // Memory / core side
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_data, redirect, redirect_target, inst_ready
  );

endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read per cycle to a
// 1-cycle-latency instruction memory, buffers returned words with their PC
// in a small FIFO and hands them to the core over valid/ready. A redirect
// loads a new PC and flushes every wrong-path word.
module inst_fetch_unit #(
  parameter int                  PC_WIDTH   = 5,
  parameter int                  INST_WIDTH = 32,
  parameter int                  DEPTH      = 3,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = {PC_WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_fetch_unit_if.master  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Circular pointer increment, wrapping at DEPTH (not a power of two in general)
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? PTR_ZERO : (p + PTR_ONE);
  endfunction

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   cap_pc_q, cap_pc_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [INST_WIDTH-1:0] mem_inst_q [DEPTH];
  logic [INST_WIDTH-1:0] mem_inst_d [DEPTH];
  logic [PC_WIDTH-1:0]   mem_pc_q   [DEPTH];
  logic [PC_WIDTH-1:0]   mem_pc_d   [DEPTH];

  logic [CNT_W:0] occ_s;
  logic           issue_s;
  logic           deq_s;
  logic           wr_s;

  // Reserve a FIFO slot for every outstanding read so a returning word always
  // fits; rst_n gating keeps the strobe low while reset is held.
  assign occ_s   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue_s = rst_n && !bus.redirect && (occ_s < DEPTH_OCC);
  assign deq_s   = (count_q != CNT_ZERO) && bus.inst_ready;
  // A word returning in a redirect cycle belongs to the wrong path
  assign wr_s    = inflight_q && !bus.redirect;

  assign bus.imem_req   = issue_s;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = (count_q != CNT_ZERO);
  assign bus.inst       = mem_inst_q[rd_ptr_q];
  assign bus.inst_pc    = mem_pc_q[rd_ptr_q];

  // Next-state: PC/issue tracking, FIFO write/read and redirect flush
  always_comb begin
    pc_d       = pc_q;
    cap_pc_d   = cap_pc_q;
    inflight_d = 1'b0;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_inst_d = mem_inst_q;
    mem_pc_d   = mem_pc_q;

    if (bus.redirect) begin
      // The head transfer in this cycle still completes; clearing the FIFO
      // after it is equivalent to just emptying it here.
      pc_d       = bus.redirect_target;
      inflight_d = 1'b0;
      count_d    = CNT_ZERO;
      wr_ptr_d   = PTR_ZERO;
      rd_ptr_d   = PTR_ZERO;
    end else begin
      if (issue_s) begin
        pc_d       = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        cap_pc_d   = pc_q;
        inflight_d = 1'b1;
      end else begin
        inflight_d = 1'b0;
      end

      if (wr_s) begin
        mem_inst_d[wr_ptr_q] = bus.imem_data;
        mem_pc_d[wr_ptr_q]   = cap_pc_q;
        wr_ptr_d             = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (deq_s) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({wr_s, deq_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; asynchronous reset discards FIFO contents and any read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      cap_pc_q   <= {PC_WIDTH{1'b0}};
      inflight_q <= 1'b0;
      count_q    <= CNT_ZERO;
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst_q[i] <= {INST_WIDTH{1'b0}};
        mem_pc_q[i]   <= {PC_WIDTH{1'b0}};
      end
    end else begin
      pc_q       <= pc_d;
      cap_pc_q   <= cap_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_inst_q <= mem_inst_d;
      mem_pc_q   <= mem_pc_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: two instances (RESET_PC 0 and 30), each
// with a synchronous memory model returning addr+0x100, and a scoreboard of
// expected (pc, inst) pairs popped on every accepted transfer.
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic rst1_n;

  always #5 clk = ~clk;

  inst_fetch_unit_if #(.PC_WIDTH(5), .INST_WIDTH(32)) b0 ();
  inst_fetch_unit_if #(.PC_WIDTH(5), .INST_WIDTH(32)) b1 ();

  inst_fetch_unit #(.PC_WIDTH(5), .INST_WIDTH(32), .DEPTH(3), .RESET_PC(5'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );

  inst_fetch_unit #(.PC_WIDTH(5), .INST_WIDTH(32), .DEPTH(3), .RESET_PC(5'd30)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(b1)
  );

  // Synchronous instruction memories: word = address + 0x100, one cycle later
  always @(posedge clk) begin
    if (b0.imem_req) b0.imem_data <= {27'd0, b0.imem_addr} + 32'h100;
    if (b1.imem_req) b1.imem_data <= {27'd0, b1.imem_addr} + 32'h100;
  end

  typedef struct {
    logic [4:0]  pc;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [4:0] p);
    q0.push_back('{p, {27'd0, p} + 32'h100});
  endtask

  task automatic push1(input logic [4:0] p);
    q1.push_back('{p, {27'd0, p} + 32'h100});
  endtask

  // Pop and compare whenever a transfer will occur at the coming edge
  task automatic sample();
    exp_t e;
    if (b0.inst_valid && b0.inst_ready) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_valid", b0.inst_valid, 1'b0);
      end else begin
        e = q0.pop_front();
        chk("dut0_inst_pc", b0.inst_pc, e.pc);
        chk("dut0_inst", b0.inst, e.data);
      end
    end
    if (rst1_n && b1.inst_valid && b1.inst_ready) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_valid", b1.inst_valid, 1'b0);
      end else begin
        e = q1.pop_front();
        chk("dut1_inst_pc", b1.inst_pc, e.pc);
        chk("dut1_inst", b1.inst, e.data);
      end
    end
  endtask

  // Cycle 0: release reset just after an edge, then sample
  task automatic release_rst(input logic rdy, input logic with1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    if (with1) rst1_n = 1'b1;
    b0.inst_ready = rdy;
    b0.redirect   = 1'b0;
    #1;
    sample();
  endtask

  // One later cycle: drive inputs after the edge, then sample
  task automatic go(input logic rdy, input logic redir, input logic [4:0] tgt);
    @(posedge clk);
    #1;
    b0.inst_ready      = rdy;
    b0.redirect        = redir;
    b0.redirect_target = tgt;
    #1;
    sample();
  endtask

  task automatic hold_reset();
    chk("q0_drain", q0.size(), 32'd0);
    chk("q1_drain", q1.size(), 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    rst1_n = 1'b0;
    b0.inst_ready = 1'b0;
    b0.redirect   = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    rst1_n = 1'b0;
    b0.inst_ready      = 1'b0;
    b0.redirect        = 1'b0;
    b0.redirect_target = 5'd0;
    b1.inst_ready      = 1'b1;
    b1.redirect        = 1'b0;
    b1.redirect_target = 5'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", b0.inst_valid, 1'b0);
    chk("rst_req", b0.imem_req, 1'b0);
    chk("rst_inst", b0.inst, 32'd0);
    chk("rst_inst_pc", b0.inst_pc, 5'd0);
    chk("rst_addr", b0.imem_addr, 5'd0);
    chk("rst1_addr", b1.imem_addr, 5'd30);

    // T1: streaming with ready high; dut1 checks PC wrap 30,31,0,1...
    for (int p = 0; p < 8; p++) push0(5'(p));
    for (int p = 0; p < 8; p++) push1(5'(30 + p));
    release_rst(1'b1, 1'b1);
    chk("t1_c0_req", b0.imem_req, 1'b1);
    chk("t1_c0_addr", b0.imem_addr, 5'd0);
    chk("t1_c0_valid", b0.inst_valid, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      go(1'b1, 1'b0, 5'd0);
      chk("t1_req", b0.imem_req, 1'b1);
      chk("t1_valid", b0.inst_valid, (k >= 2) ? 1'b1 : 1'b0);
    end
    hold_reset();

    // T2: ready low fills the FIFO with 3 reads, then drains in order
    for (int p = 0; p < 4; p++) push0(5'(p));
    release_rst(1'b0, 1'b0);
    chk("t2_c0_req", b0.imem_req, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      go(1'b0, 1'b0, 5'd0);
      chk("t2_req", b0.imem_req, (k <= 2) ? 1'b1 : 1'b0);
      if (k <= 2) chk("t2_addr", b0.imem_addr, 5'(k));
      chk("t2_valid", b0.inst_valid, (k >= 2) ? 1'b1 : 1'b0);
      if (k >= 2) chk("t2_hold_pc", b0.inst_pc, 5'd0);
    end
    go(1'b1, 1'b0, 5'd0);
    chk("t2_c8_req", b0.imem_req, 1'b0);
    go(1'b1, 1'b0, 5'd0);
    chk("t2_c9_req", b0.imem_req, 1'b1);
    chk("t2_c9_addr", b0.imem_addr, 5'd3);
    go(1'b1, 1'b0, 5'd0);
    go(1'b1, 1'b0, 5'd0);
    hold_reset();

    // T3: redirect to 20 in cycle 6 of a steady stream
    for (int p = 0; p < 5; p++) push0(5'(p));
    push0(5'd20);
    push0(5'd21);
    release_rst(1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      go(1'b1, (k == 6) ? 1'b1 : 1'b0, 5'd20);
      if (k == 6) chk("t3_redir_req", b0.imem_req, 1'b0);
      if (k == 7) begin
        chk("t3_req_tgt", b0.imem_req, 1'b1);
        chk("t3_addr_tgt", b0.imem_addr, 5'd20);
      end
      if (k == 7 || k == 8) chk("t3_bubble_valid", b0.inst_valid, 1'b0);
    end
    hold_reset();

    // T4: redirect with a head transfer, then again next cycle (5 then 9)
    push0(5'd0);
    push0(5'd1);
    push0(5'd2);
    push0(5'd9);
    push0(5'd10);
    release_rst(1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      go(1'b1, (k == 4 || k == 5) ? 1'b1 : 1'b0, (k == 4) ? 5'd5 : 5'd9);
      if (k == 4 || k == 5) chk("t4_redir_req", b0.imem_req, 1'b0);
      if (k == 6) begin
        chk("t4_req_tgt", b0.imem_req, 1'b1);
        chk("t4_addr_tgt", b0.imem_addr, 5'd9);
      end
      if (k >= 5 && k <= 7) chk("t4_bubble_valid", b0.inst_valid, 1'b0);
    end
    hold_reset();

    // T5: asynchronous reset mid-cycle with two entries buffered
    release_rst(1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) go(1'b0, 1'b0, 5'd0);
    chk("t5_pre_valid", b0.inst_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", b0.inst_valid, 1'b0);
    chk("t5_async_req", b0.imem_req, 1'b0);
    chk("t5_async_inst", b0.inst, 32'd0);
    repeat (2) @(posedge clk);
    push0(5'd0);
    push0(5'd1);
    push0(5'd2);
    release_rst(1'b1, 1'b0);
    chk("t5_c0_addr", b0.imem_addr, 5'd0);
    chk("t5_c0_valid", b0.inst_valid, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      go(1'b1, 1'b0, 5'd0);
      chk("t5_valid", b0.inst_valid, (k >= 2) ? 1'b1 : 1'b0);
    end
    hold_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage that feeds the decode/execute core.
- Owns the program counter and issues one read per cycle to a synchronous instruction memory (1-cycle read latency).
- Buffers returned words with their PC in a small FIFO and presents them to the core over a valid/ready handshake.
- Accepts absolute branch redirects from the core and flushes all wrong-path state.

Parameters:
- PC_WIDTH, 5, width of PC and instruction-memory address; PC arithmetic wraps modulo 2^PC_WIDTH.
- INST_WIDTH, 32, instruction word width.
- DEPTH, 3, FIFO entries; legal range 2..4. DEPTH≥3 sustains 1 inst/cycle.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset.
- imem_req  out  1  read strobe to instruction memory.
- imem_addr  out  PC_WIDTH  read address; equals the PC register.
- imem_data  in  INST_WIDTH  read data; valid in the cycle after imem_req.
- redirect  in  1  branch taken; load redirect_target.
- redirect_target  in  PC_WIDTH  absolute new PC.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  core accepts head.
- inst  out  INST_WIDTH  head instruction.
- inst_pc  out  PC_WIDTH  PC of head instruction.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - pc = RESET_PC, FIFO empty, inflight = 0.
  - inst_valid = 0, inst = 0, inst_pc = 0.
  - imem_req = 0 while rst_n is low.
  - Reset mid-operation discards all FIFO contents and any in-flight read.
- Issue rule:
  - imem_req = !redirect && (count + inflight < DEPTH), combinational from registered state only. It never depends on inst_ready.
  - On an issuing edge: inflight <= 1, captured_pc <= pc, pc <= pc + 1 (31+1 wraps to 0 at PC_WIDTH = 5).
- Return rule:
  - The cycle after an issue, imem_data is written into the FIFO tail together with captured_pc, unless that read was killed.
  - inflight clears on the same edge.
- Latency: request in cycle N → entry written at the end of cycle N+1 → inst_valid high in cycle N+2. There is no bypass path.
- Handshake:
  - A transfer occurs when inst_valid && inst_ready.
  - inst and inst_pc hold stable while valid && !ready.
  - Simultaneous write and read with count = DEPTH cannot occur: the issue rule guarantees space.
  - Simultaneous write and read with count = 0 behaves as a plain write; the head appears next cycle.
- Redirect (highest priority):
  - A transfer of the head in the redirect cycle completes normally.
  - Then the FIFO is cleared, pc <= redirect_target, and any in-flight read is marked killed; its data is dropped next cycle.
  - No request is issued in the redirect cycle.
  - The first request at redirect_target goes out the following cycle; its inst_valid follows 2 cycles later.
  - Back-to-back redirects: the last one wins.
- Empty: inst_valid = 0; inst and inst_pc hold their last value (don't-care for verification).
- Full: imem_req = 0 until a dequeue frees space.
- Count width is clog2(DEPTH+1). Pointers wrap modulo DEPTH.

Test Plan:
- Reset release, inst_ready = 1, imem returns addr+0x100: imem_req in cycles 0,1,2…; inst_valid first in cycle 2 with inst = 0x100, inst_pc = 0; then one instruction per cycle with pc 1, 2, 3…
- inst_ready = 0 from cycle 0: exactly 3 reads issued (addr 0,1,2), imem_req then low. Raise ready in cycle 8: heads pc 0,1,2 delivered in order, and fetch resumes at addr 3.
- Steady stream; redirect = 1, target = 20 in cycle 6: the in-flight word is dropped, no inst_valid for the following 2 cycles, next accepted inst_pc = 20, then 21.
- PC wrap: RESET_PC = 30 → inst_pc sequence 30, 31, 0, 1.
- Redirect asserted together with a head transfer, and in 2 consecutive cycles (targets 5 then 9): head accepted once; the first post-redirect inst_pc is 9.
- Assert rst_n low asynchronously mid-stream with FIFO holding 2 entries: inst_valid and imem_req drop immediately without waiting for a clk edge; after release, fetch restarts at RESET_PC with no stale data delivered.
